// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: AHB-Lite data-port bundle between the memory stage (master)
// and the data memory / interconnect (slave).
//   haddr, htrans, hwrite, hsize, hwdata : master -> slave
//   hrdata, hready, hresp                : slave  -> master
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [XLEN-1:0] hwdata;
  logic [XLEN-1:0] hrdata;
  logic            hready;
  logic            hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory pipeline stage. Takes the execute result, or performs a
// byte/half/word load/store as an AHB-Lite master, and emits a registered
// writeback bundle.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready execute -> mem handshake. A transfer happens on a rising
//                     edge where in_valid & in_ready are both 1; in_valid may
//                     be held with changing payload, in_ready is high only in
//                     IDLE and does not depend on in_valid.
//   in_*              instruction payload (load/store flags, size, sign, address,
//                     store data, execute result, destination register)
//   ahb               AHB-Lite master port (see mem_stage_lsu_if)
//   wb_valid/rd/data  one-cycle writeback pulse to the register file
//   misalign_err      one-cycle pulse, misaligned access rejected
//   bus_err           one-cycle pulse, AHB ERROR response received
//   state_dbg         current FSM state (0=IDLE, 1=ADDR, 2=DATA)
module mem_stage_lsu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_ex_res,
  input  logic [RD_W-1:0] in_rd,
  mem_stage_lsu_if.master ahb,
  output logic            wb_valid,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err,
  output logic            bus_err,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t state, state_nxt;

  // Latched access, held stable for the whole address and data phases.
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic            unsigned_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] wdata_q;

  logic            accept;
  logic            is_mem;
  logic [1:0]      size_eff;
  logic            misaligned;
  logic            start_mem;
  logic [XLEN-1:0] wdata_rep;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_data;

  // Request decode
  assign accept   = in_valid & in_ready;
  assign is_mem   = in_load | in_store;
  // Size 3 is illegal; handle it exactly like a word access.
  assign size_eff = (in_size == 2'd3) ? 2'd2 : in_size;

  always_comb begin
    misaligned = 1'b0;
    if (is_mem) begin
      case (size_eff)
        2'd1:    misaligned = in_addr[0];
        2'd2:    misaligned = |in_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign start_mem = accept & is_mem & ~misaligned;

  // Store data replicated across all byte lanes so the slave can pick the lane
  // addressed by haddr[1:0] without any shifting.
  always_comb begin
    case (size_eff)
      2'd0:    wdata_rep = {4{in_wdata[7:0]}};
      2'd1:    wdata_rep = {2{in_wdata[15:0]}};
      default: wdata_rep = in_wdata;
    endcase
  end

  // Load lane extraction
  assign load_byte = ahb.hrdata[{addr_q[1:0], 3'b000} +: 8];
  assign load_half = ahb.hrdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    load_data = unsigned_q ? {24'd0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'd1:    load_data = unsigned_q ? {16'd0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_data = ahb.hrdata;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_mem) state_nxt = S_ADDR;
      S_ADDR:  if (ahb.hready) state_nxt = S_DATA;
      // hresp during hready=0 is the first cycle of a two-cycle ERROR; only
      // the hready=1 cycle ends the data phase.
      S_DATA:  if (ahb.hready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready    = (state == S_IDLE);
    ahb.htrans  = (state == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    ahb.hwrite  = (state == S_ADDR) & write_q;
    ahb.haddr   = addr_q;
    ahb.hsize   = {1'b0, size_q};
    ahb.hwdata  = wdata_q;
    state_dbg   = state;
  end

  // Access latch and writeback / error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      size_q       <= '0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;

      if (accept) begin
        if (!is_mem) begin
          wb_valid <= |in_rd;
          wb_rd    <= in_rd;
          wb_data  <= in_ex_res;
        end else if (misaligned) begin
          misalign_err <= 1'b1;
        end else begin
          addr_q     <= in_addr;
          size_q     <= size_eff;
          write_q    <= in_store;
          unsigned_q <= in_unsigned;
          rd_q       <= in_rd;
          wdata_q    <= wdata_rep;
        end
      end

      if (state == S_DATA && ahb.hready) begin
        if (ahb.hresp) begin
          bus_err <= 1'b1;
        end else if (!write_q) begin
          wb_valid <= |rd_q;
          wb_rd    <= rd_q;
          wb_data  <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios followed by random
// transactions checked against a transaction-level reference model.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_load;
  logic        in_store;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_ex_res;
  logic [4:0]  in_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        bus_err;
  logic [1:0]  state_dbg;

  mem_stage_lsu_if #(.XLEN(32)) bus ();

  mem_stage_lsu #(.XLEN(32), .RD_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_load      (in_load),
    .in_store     (in_store),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_ex_res    (in_ex_res),
    .in_rd        (in_rd),
    .ahb          (bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];   // {rd, data} of expected writebacks

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic [31:0] ref_store_lanes(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0)      return d[7:0] * 32'h0101_0101;
    else if (size == 2'd1) return d[15:0] * 32'h0001_0001;
    else                   return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                           input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (d >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (d >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Scoreboard: compare the writeback seen now with the expected one.
  task automatic check_wb(input string tag, input bit expect_wb);
    logic [36:0] e;
    chk({tag, "_wb_valid"}, wb_valid, expect_wb);
    if (expect_wb) begin
      e = exp_q.pop_front();
      if (wb_valid) chk({tag, "_wb_bundle"}, {wb_rd, wb_data}, e);
    end
  endtask

  // Driver: one instruction from issue to completion. kind 0=alu, 1=load, 2=store.
  task automatic run_op(input string tag, input int kind, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] ex_res, input logic [4:0] rd,
                        input int addr_waits, input int data_waits, input logic err,
                        input logic [31:0] rdata);
    int nbytes;
    bit aligned;
    logic [31:0] exp_wd;
    nbytes  = 1 << size;
    aligned = (addr % nbytes) == 0;
    exp_wd  = ref_store_lanes(size, wdata);

    @(negedge clk);
    chk({tag, "_ready_idle"}, in_ready, 1'b1);
    chk({tag, "_pulses_clear"}, {wb_valid, misalign_err, bus_err}, 3'b000);
    in_valid = 1'b1; in_load = (kind == 1); in_store = (kind == 2);
    in_size = size; in_unsigned = uns; in_addr = addr; in_wdata = wdata;
    in_ex_res = ex_res; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;

    if (kind == 0) begin
      if (rd != 0) exp_q.push_back({rd, ex_res});
      check_wb(tag, rd != 0);
      chk({tag, "_htrans"}, bus.htrans, 2'b00);
    end else if (!aligned) begin
      chk({tag, "_misalign"}, misalign_err, 1'b1);
      chk({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk({tag, "_htrans"}, bus.htrans, 2'b00);
      chk({tag, "_ready"}, in_ready, 1'b1);
    end else begin
      chk({tag, "_htrans_a"}, bus.htrans, 2'b10);
      chk({tag, "_haddr"}, bus.haddr, addr);
      chk({tag, "_hsize"}, bus.hsize, {1'b0, size});
      chk({tag, "_hwrite"}, bus.hwrite, kind == 2);
      chk({tag, "_ready_busy"}, in_ready, 1'b0);
      for (int i = 0; i < addr_waits; i++) begin
        bus.hready = 1'b0;
        @(negedge clk);
        chk({tag, "_htrans_hold"}, bus.htrans, 2'b10);
        chk({tag, "_haddr_hold"}, bus.haddr, addr);
      end
      bus.hready = 1'b1;
      @(negedge clk);
      chk({tag, "_htrans_d"}, bus.htrans, 2'b00);
      chk({tag, "_hwdata"}, bus.hwdata, exp_wd);
      chk({tag, "_ready_data"}, in_ready, 1'b0);
      for (int i = 0; i < data_waits; i++) begin
        bus.hready = 1'b0;
        bus.hresp  = err && (i == data_waits - 1);
        bus.hrdata = $urandom;
        @(negedge clk);
        chk({tag, "_hwdata_hold"}, bus.hwdata, exp_wd);
        chk({tag, "_wait_quiet"}, {wb_valid, bus_err, in_ready}, 3'b000);
      end
      bus.hready = 1'b1;
      bus.hresp  = err;
      bus.hrdata = rdata;
      @(negedge clk);
      bus.hresp = 1'b0;
      chk({tag, "_ready_back"}, in_ready, 1'b1);
      chk({tag, "_misalign_q"}, misalign_err, 1'b0);
      if (err) begin
        chk({tag, "_bus_err"}, bus_err, 1'b1);
        chk({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_state"}, state_dbg, 2'd0);
      end else if (kind == 1) begin
        if (rd != 0) exp_q.push_back({rd, ref_load(size, uns, addr, rdata)});
        check_wb(tag, rd != 0);
        chk({tag, "_bus_err"}, bus_err, 1'b0);
      end else begin
        chk({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_bus_err"}, bus_err, 1'b0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0;
    in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_ex_res = '0; in_rd = '0;
    bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_htrans", bus.htrans, 2'b00);
    chk("rst_hwrite", bus.hwrite, 1'b0);
    chk("rst_haddr", bus.haddr, 32'd0);
    chk("rst_hsize", bus.hsize, 3'd0);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_wb", {wb_valid, wb_rd, wb_data}, 38'd0);
    chk("rst_errs", {misalign_err, bus_err}, 2'b00);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Non-memory back-to-back at full throughput
    @(negedge clk);
    in_valid = 1'b1; in_ex_res = 32'h1234; in_rd = 5'd5;
    @(negedge clk);
    in_ex_res = 32'hABCD; in_rd = 5'd0;
    exp_q.push_back({5'd5, 32'h1234});
    check_wb("b2b_c1", 1'b1);
    chk("b2b_ready1", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_c2_wb_valid", wb_valid, 1'b0);
    chk("b2b_ready2", in_ready, 1'b1);

    // Directed memory cases
    run_op("lb_s", 1, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h0, 5'd3, 0, 0, 1'b0, 32'h80FF_0011);
    run_op("lbu", 1, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h0, 5'd3, 0, 0, 1'b0, 32'h80FF_0011);
    run_op("sh_wait", 2, 2'd1, 1'b0, 32'h2002, 32'hDEAD_BEEF, 32'h0, 5'd4, 0, 2, 1'b0, 32'h0);
    run_op("lw_mis", 1, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd6, 0, 0, 1'b0, 32'h0);
    run_op("lw_err", 1, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd7, 0, 1, 1'b1, 32'h0);
    run_op("lh_awt", 1, 2'd1, 1'b0, 32'h5002, 32'h0, 32'h0, 5'd9, 1, 0, 1'b0, 32'h8001_7FFF);

    // Reset during a DATA wait state
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b1; in_size = 2'd2; in_addr = 32'h40; in_rd = 5'd7;
    @(negedge clk);
    in_valid = 1'b0; in_load = 1'b0;
    @(negedge clk);
    bus.hready = 1'b0;
    @(negedge clk);
    chk("rstmid_in_data", bus.hwdata !== 32'hx && in_ready == 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_htrans", bus.htrans, 2'b00);
    chk("rstmid_ready", in_ready, 1'b1);
    chk("rstmid_quiet", {wb_valid, bus_err}, 2'b00);
    bus.hready = 1'b1;
    @(negedge clk);
    chk("rstmid_after", {wb_valid, bus_err, in_ready}, 3'b001);

    // Random transactions
    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [1:0] size;
      logic [31:0] addr;
      kind = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      run_op("rnd", kind, size, 1'($urandom_range(0, 1)), addr, $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 1), $urandom_range(0, 2),
             $urandom_range(0, 7) == 0, $urandom);
    end

    @(negedge clk);
    chk("end_quiet", {wb_valid, misalign_err, bus_err}, 3'b000);
    chk("end_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the ALU/mul/div result, the computed load/store address, and the store data. Performs byte/half/word load/store accesses as an AHB-Lite data-port master.
- Produces a registered writeback bundle (rd, data) for the register file.
- Back-pressures execute via in_ready while a bus access is outstanding.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  stage accepts; transfer occurs when in_valid&in_ready.
- in_load  in  1  instruction is a load.
- in_store  in  1  instruction is a store (never set together with in_load).
- in_size  in  2  0=byte, 1=half, 2=word; 3 is illegal and treated as word.
- in_unsigned  in  1  zero-extend load (LBU/LHU).
- in_addr  in  XLEN  effective address (execute adder result).
- in_wdata  in  XLEN  store data (rs2).
- in_ex_res  in  XLEN  execute result for non-memory instructions.
- in_rd  in  RD_W  destination register; 0 means no write.
- haddr  out  XLEN  AHB address.
- htrans  out  2  AHB transfer type; only IDLE=2'b00 and NONSEQ=2'b10 are used.
- hwrite  out  1  AHB write.
- hsize  out  3  AHB size = {1'b0, in_size}.
- hwdata  out  XLEN  AHB write data, driven in the data phase.
- hrdata  in  XLEN  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  1  AHB response; 1 = ERROR.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  RD_W  writeback register.
- wb_data  out  XLEN  writeback data.
- misalign_err  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: AHB ERROR response received.

Behaviour:
- Reset: state=IDLE, htrans=IDLE, hwrite=0, haddr=0, hsize=0, hwdata=0, wb_valid=0, wb_rd=0, wb_data=0, misalign_err=0, bus_err=0, in_ready=1 in the cycle after the reset edge.
- Reset asserted mid-access abandons the access immediately; no writeback or error pulse follows.
- States:
  - IDLE: in_ready=1.
  - ADDR: htrans=NONSEQ, address phase.
  - DATA: htrans=IDLE, hwdata valid.
  - in_ready=0 in ADDR and DATA.
- IDLE, accept of a non-memory instruction: next cycle wb_valid=(in_rd!=0), wb_rd=in_rd, wb_data=in_ex_res. Stay in IDLE. Throughput is 1/cycle.
- Alignment rule: half requires addr[0]=0; word requires addr[1:0]=0.
- IDLE, accept of a misaligned memory instruction: next cycle misalign_err=1, wb_valid=0, no bus transfer, stay in IDLE.
- IDLE, accept of an aligned memory instruction:
  - Register addr, size, write flag, rd and lane-replicated store data, then go to ADDR.
  - Store data replication: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
- ADDR: drive haddr/hwrite/hsize with htrans=NONSEQ. If hready, go to DATA; otherwise hold all address-phase signals and stay in ADDR.
- DATA: drive hwdata (held stable throughout the phase).
  - hready=1, hresp=0, load: next cycle wb_valid=(rd!=0), wb_data=extracted lane. Go to IDLE.
  - hready=1, hresp=0, store: no wb_valid. Go to IDLE.
  - hready=1, hresp=1: next cycle bus_err=1, no writeback. Go to IDLE.
  - hready=0: stay in DATA. hresp may be 1 in the first ERROR cycle; it is ignored until hready=1.
- Load extraction:
  - byte = hrdata[8*addr[1:0] +: 8].
  - half = hrdata[16*addr[1] +: 16].
  - Sign-extend unless in_unsigned; word passes unchanged.
- Zero-wait load latency: accept at edge E0; ADDR cycle after E0; DATA cycle after E1; wb_valid in the cycle after E2; in_ready high again in that same cycle.
- A memory op takes 2 cycles plus wait states. Accesses never overlap; back-to-back memory ops have 1 idle bus cycle.
- wb_valid, misalign_err and bus_err are mutually exclusive and each lasts exactly one cycle.

Test Plan:
- Non-memory back-to-back: ex_res=0x1234 rd=5, then ex_res=0xABCD rd=0 -> wb_valid=1, wb_data=0x1234, wb_rd=5 in cycle 1; wb_valid=0 in cycle 2; in_ready stays 1.
- Load byte signed, addr=0x1003, hrdata=0x80FF_0011, zero wait -> haddr=0x1003, hsize=0, NONSEQ for one cycle; wb_data=0xFFFF_FF80 three cycles after accept. Repeat with in_unsigned=1 -> wb_data=0x0000_0080.
- Store half, addr=0x2002, wdata=0xDEAD_BEEF, hready low for 2 DATA cycles -> hwdata=0xBEEF_BEEF held for 3 cycles, hwrite=1, no wb_valid; in_ready returns after hready.
- Misaligned word load, addr=0x3001 -> misalign_err pulse next cycle, htrans stays IDLE, no wb_valid.
- Two-cycle ERROR response on a load (hready=0/hresp=1, then hready=1/hresp=1) -> bus_err pulse once, wb_valid=0, state returns to IDLE.
- rst asserted during a DATA wait -> next cycle htrans=IDLE, in_ready=1, no wb_valid or bus_err.
